// File: rtl/sd_modulator_mc.sv
// -----------------------------------------------------------------------------
// sd_modulator_mc
//
// Multi-channel sigma-delta modulator with a 1-bit quantiser. The loop order
// is configurable from 1 to 4. Every channel owns a cascade of ORDER
// integrators. Each integrator accumulates the previous stage output minus the
// +/-1.0 feedback. The sign of the last integrator gives the output bit.
//
// Build option:
//   SD_MODULATOR_SAT_EN  defined   -> out-of-range sums clamp to the W-bit limits
//                        undefined -> out-of-range sums wrap modulo 2^W
//   Overflow detection (ovf) is active in both builds.
//
// Parameters:
//   W      integrator and input width, signed two's complement
//   Q      fractional bits; +1.0 == 2^Q (Q <= W-3)
//   N      number of independent channels
//   ORDER  loop order, 1..4
//
// Ports:
//   clk      sole clock, rising edge
//   reset    synchronous, active-high; clears integrators and overflow flags
//   enb      sample strobe shared by all channels
//   in       channel c input in bits [c*W +: W], signed
//   clr_ovf  clears every sticky overflow flag (a new overflow on the same edge wins)
//   out      1-bit modulator output per channel, decoded from the last integrator
//   ovf      sticky integrator-overflow flag per channel
// -----------------------------------------------------------------------------
module sd_modulator_mc #(
    parameter int W     = 16,
    parameter int Q     = 13,
    parameter int N     = 2,
    parameter int ORDER = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enb,
    input  logic [N*W-1:0] in,
    input  logic           clr_ovf,
    output logic [N-1:0]   out,
    output logic [N-1:0]   ovf
);

    // Full-precision width: it holds the input plus ORDER integrators and the
    // feedback terms without any intermediate truncation.
    localparam int SW = W + ORDER + 1;

    localparam logic signed [SW-1:0] FB_POS  = SW'(1) << Q;
    localparam logic signed [SW-1:0] SUM_MAX = (SW'(1) << (W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SUM_MIN = -(SW'(1) << (W - 1));

`ifdef SD_MODULATOR_SAT_EN
    localparam logic signed [W-1:0] Z_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0] Z_MIN = {1'b1, {(W - 1){1'b0}}};
`endif

    logic signed [W-1:0] z_q [N][ORDER];
    logic signed [W-1:0] z_d [N][ORDER];
    logic [N-1:0]        ovf_q;
    logic [N-1:0]        ovf_d;

    // The output bit is 1 only for a strictly positive last integrator.
    always_comb begin
        out = '0;
        for (int c = 0; c < N; c++) begin
            out[c] = !z_q[c][ORDER-1][W-1] && (z_q[c][ORDER-1] != '0);
        end
    end

    assign ovf = ovf_q;

    always_comb begin : p_integrate
        logic signed [SW-1:0] fb;
        logic signed [SW-1:0] acc;
        logic signed [W-1:0]  stage;
        logic                 hit;
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path can leave it unassigned and infer a latch.
        z_d   = z_q;
        ovf_d = ovf_q;
        fb    = '0;
        acc   = '0;
        stage = '0;
        hit   = 1'b0;
        for (int c = 0; c < N; c++) begin
            fb    = out[c] ? FB_POS : -FB_POS;
            stage = in[c*W +: W];
            hit   = 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                // stage carries the reduced sum of the previous integrator;
                // for k == 0 it carries the channel input.
                acc = SW'(stage) - fb + SW'(z_q[c][k]);
                if (acc > SUM_MAX || acc < SUM_MIN) begin
                    hit = 1'b1;
                end
`ifdef SD_MODULATOR_SAT_EN
                if (acc > SUM_MAX) begin
                    stage = Z_MAX;
                end else if (acc < SUM_MIN) begin
                    stage = Z_MIN;
                end else begin
                    stage = acc[W-1:0];
                end
`else
                stage = acc[W-1:0];
`endif
                if (enb) begin
                    z_d[c][k] = stage;
                end
            end
            // Set wins over clear on the same edge.
            ovf_d[c] = (ovf_q[c] && !clr_ovf) || (enb && hit);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the integrator array is real loop state, not storage
            // memory; it must be cleared so the first sample after reset starts
            // from zero.
            z_q   <= '{default: '0};
            ovf_q <= '0;
        end else begin
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sd_modulator_mc.sv
// -----------------------------------------------------------------------------
// tb_sd_modulator_mc
//
// Scoreboard bench for sd_modulator_mc (W=16, Q=13, N=2, ORDER=2). The
// stimulus drives one sample per cycle on the falling edge and pushes the
// expected post-edge response into a queue. A monitor pops the queue one
// time unit after each rising edge and compares the response. The sequences
// were derived by hand from the loop equations.
// -----------------------------------------------------------------------------
module tb_sd_modulator_mc;

    localparam int W     = 16;
    localparam int Q     = 13;
    localparam int N     = 2;
    localparam int ORDER = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           enb;
    logic [N*W-1:0] in;
    logic           clr_ovf;
    logic [N-1:0]   out;
    logic [N-1:0]   ovf;

    sd_modulator_mc #(.W(W), .Q(Q), .N(N), .ORDER(ORDER)) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .in      (in),
        .clr_ovf (clr_ovf),
        .out     (out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        logic [1:0] out;
        logic [1:0] out_mask;
        logic [1:0] ovf;
        bit       chk_z;
        int       zc;
        int       z0;
        int       z1;
        bit       count;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ones0 = 0;
    int   ones1 = 0;

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [1:0] o,
                                input logic [1:0] m, input logic [1:0] v);
        exp_t e;
        e.tag      = tag;
        e.out      = o;
        e.out_mask = m;
        e.ovf      = v;
        e.chk_z    = 1'b0;
        e.zc       = 0;
        e.z0       = 0;
        e.z1       = 0;
        e.count    = 1'b0;
        return e;
    endfunction

    // Output for zero input, i = enb edges since reset (1-based): 1,1,0,0,...
    function automatic logic seq(input int i);
        return ((i - 1) % 4) < 2;
    endfunction

    task automatic step(input bit rst, input bit en, input logic [15:0] i0,
                        input logic [15:0] i1, input bit clr, input exp_t e);
        @(negedge clk);
        reset   = rst;
        enb     = en;
        in      = {i1, i0};
        clr_ovf = clr;
        q.push_back(e);
    endtask

    // Monitor: compares one expectation per rising edge, away from the edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.out_mask != 2'b00) begin
                    check({e.tag, "/out"}, out & e.out_mask, e.out & e.out_mask);
                end
                check({e.tag, "/ovf"}, ovf, e.ovf);
                if (e.chk_z) begin
                    check({e.tag, "/z0"}, dut.z_q[e.zc][0], e.z0);
                    check({e.tag, "/z1"}, dut.z_q[e.zc][1], e.z1);
                end
                if (e.count) begin
                    ones0 += int'(out[0]);
                    ones1 += int'(out[1]);
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic b;
        int   edges;
        bit   en_pat [7] = '{1, 0, 0, 1, 1, 1, 1};

        reset   = 1'b1;
        enb     = 1'b0;
        in      = '0;
        clr_ovf = 1'b0;

        // Reset state, then the zero-input limit cycle on both channels.
        e = mk("rst", 2'b00, 2'b11, 2'b00);
        e.chk_z = 1'b1;
        step(1, 1, 0, 0, 0, e);
        for (int i = 1; i <= 8; i++) begin
            b = seq(i);
            step(0, 1, 0, 0, 0, mk($sformatf("seq%0d", i), {b, b}, 2'b11, 2'b00));
        end

        // Strobe gating: state and output freeze while enb is low.
        step(1, 0, 0, 0, 0, mk("rst_b", 2'b00, 2'b11, 2'b00));
        edges = 0;
        for (int i = 0; i < 7; i++) begin
            if (en_pat[i]) edges++;
            b = seq(edges);
            e = mk($sformatf("hold%0d", i), {b, b}, 2'b11, 2'b00);
            if (edges == 1) begin
                e.chk_z = 1'b1;
                e.zc    = 1;
                e.z0    = 8192;
                e.z1    = 16384;
            end
            step(0, en_pat[i], 0, 0, 0, e);
        end

        // Overflow on channel 0 with clr_ovf on the same edge: set wins.
        step(1, 1, 0, 0, 0, mk("rst_c", 2'b00, 2'b11, 2'b00));
`ifdef SD_MODULATOR_SAT_EN
        e = mk("ovf_set", 2'b11, 2'b11, 2'b01);
        e.z0 = 32767;
        e.z1 = 32767;
`else
        e = mk("ovf_set", 2'b10, 2'b11, 2'b01);
        e.z0 = -24577;
        e.z1 = -16385;
`endif
        e.chk_z = 1'b1;
        step(0, 1, 16'd32767, 0, 1, e);
        for (int i = 2; i <= 41; i++) begin
            b = seq(i);
            step(0, 1, 0, 0, 0, mk($sformatf("ovf_hold%0d", i), {b, 1'b0}, 2'b10, 2'b01));
        end
        step(0, 1, 0, 0, 1, mk("ovf_clr", {seq(42), 1'b0}, 2'b10, 2'b00));
        for (int i = 43; i <= 45; i++) begin
            b = seq(i);
            step(0, 1, 0, 0, 0, mk($sformatf("ovf_clean%0d", i), {b, 1'b0}, 2'b10, 2'b00));
        end

        // Mid-stream reset with enb high, then the sequence restarts.
        e = mk("midrst", 2'b00, 2'b11, 2'b00);
        e.chk_z = 1'b1;
        step(1, 1, 0, 0, 0, e);
        for (int i = 1; i <= 5; i++) begin
            b = seq(i);
            step(0, 1, 0, 0, 0, mk($sformatf("restart%0d", i), {b, b}, 2'b11, 2'b00));
        end

        // Ones density for +0.5 input on both channels.
        step(1, 1, 0, 0, 0, mk("rst_e", 2'b00, 2'b11, 2'b00));
        for (int i = 0; i < 4096; i++) begin
            e = mk("dens", 2'b00, 2'b00, 2'b00);
            e.count = 1'b1;
            step(0, 1, 16'd4096, 16'd4096, 0, e);
        end

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 8; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check("drain", q.size(), 0);

        n_cmp++;
        if (ones0 < 3031 || ones0 > 3113) begin
            n_bad++;
            $display("FAIL dens0: ones=%0d, expected 3031..3113", ones0);
        end
        n_cmp++;
        if (ones1 < 3031 || ones1 > 3113) begin
            n_bad++;
            $display("FAIL dens1: ones=%0d, expected 3031..3113", ones1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_modulator_mc.md
SD_MODULATOR_MC -- requirements
Module: sd_modulator_mc

Interface
REQ-001 SHALL have parameter W, default 16: integrator and input width in bits, signed two's complement.
REQ-002 SHALL have parameter Q, default 13: fractional bits; full-scale +1.0 equals 2^Q, with Q <= W-3.
REQ-003 SHALL have parameter N, default 2: number of independent modulator channels.
REQ-004 SHALL have parameter ORDER, default 2: loop order, legal values 1 to 4.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enb, input, 1 bit: modulator sample strobe shared by all channels.
REQ-008 SHALL have port in, input, N*W bits: channel c input in bits [c*W +: W], signed.
REQ-009 SHALL have port clr_ovf, input, 1 bit: clears all sticky overflow flags.
REQ-010 SHALL have port out, output, N bits: 1-bit modulator output per channel.
REQ-011 SHALL have port ovf, output, N bits: sticky integrator-overflow flag per channel.

Function
REQ-012 SHALL keep per channel ORDER integrator registers z[0..ORDER-1], each W bits signed.
REQ-013 SHALL derive the feedback fb = +2^Q when out[c]=1 and fb = -2^Q when out[c]=0.
REQ-014 SHALL compute sum[0] = in_c - fb + z[0], and sum[k] = sum[k-1] - fb + z[k] for k = 1 to ORDER-1, in W+ORDER+1-bit arithmetic with no intermediate truncation.
REQ-015 SHALL reduce each sum[k] to W bits before it is stored, and before it is passed as sum[k-1] to the next stage, as defined in the Configuration section.
REQ-016 SHALL load z[k] <= reduced sum[k] on a clk edge with enb=1; z SHALL hold when enb=0.
REQ-017 SHALL drive out[c] = 1 when z[ORDER-1] > 0, else 0, decoded combinationally from the register; out therefore changes only the cycle after an enb edge.
REQ-018 SHALL set ovf[c] on an enb edge when any full-precision sum[k] of channel c lies outside the signed W-bit range.
REQ-019 SHALL clear ovf[c] on a clk edge with clr_ovf=1; if overflow and clr_ovf occur on the same edge, the flag SHALL be set (set wins).
REQ-020 SHALL operate channels fully independently; an overflow on one channel SHALL NOT alter the state of another channel.

Reset
REQ-021 SHALL, on a clk edge with reset=1, clear all z to 0 and all ovf to 0, regardless of enb and clr_ovf.
REQ-022 SHALL therefore present out = all zeros and ovf = all zeros from the first edge after reset asserts.
REQ-023 SHALL discard any in-progress sample on mid-operation reset; the first enb edge after release SHALL use z = 0.

Configuration
REQ-024 SHALL, when macro SD_MODULATOR_SAT_EN is defined, clamp each out-of-range sum[k] to +(2^(W-1)-1) or -2^(W-1).
REQ-025 SHALL, when SD_MODULATOR_SAT_EN is undefined, wrap each sum[k] modulo 2^W (two's-complement truncation); ovf detection SHALL remain active in both builds.

Verification
REQ-026 SHALL verify, with W=16, Q=13, ORDER=2, in=0 and enb=1 constantly from reset: out sequence 0,1,1,0 repeating, and ovf=0.
REQ-027 SHALL verify, with in=4096 (+0.5) over 4096 enb cycles: out ones-density 75% +/-1%, ovf=0.
REQ-028 SHALL verify, with enb toggled 1,0,0,1: z and out are frozen during enb=0 cycles, and the sequence continues unchanged afterward.
REQ-029 SHALL verify, with in=32767 on channel 0 and in=0 on channel 1: ovf[0]=1 within 4 enb cycles, ovf[1]=0, and channel 1 output matches REQ-026; saturate build shows z clamped to 32767, wrap build shows a negative z.
REQ-030 SHALL verify that clr_ovf=1 pulsed during continued overflow keeps ovf[0]=1 (set wins), and that after in returns to 0 a clr_ovf pulse clears ovf[0] to 0.
REQ-031 SHALL verify that reset asserted mid-stream with enb=1 gives z=0, out=0 and ovf=0 on the next edge, and that after release the REQ-026 sequence restarts from its first value.
